inst_encoder: RTL

Pipelined RISC-V RV32I instruction encoder: the inverse of the core's immediate extraction. It accepts decoded instruction fields (opcode, registers, funct3/funct7, full 32-bit immediate), range-checks the immediate, and packs everything into a 32-bit instruction word. Each word is presented with a target address on a valid/ready stream. It sits between the debug/boot loader front end and the instruction-memory write port.

---
 rtl/rv32_pkg.sv | 36 +++
 rtl/inst_encoder_if.sv | 29 ++
 rtl/inst_encoder_imm_pack.sv | 60 ++++++
 rtl/inst_encoder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// RV32I encoding constants and helpers shared by the encoder and the immediate extractor.
package rv32_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  func3;
      logic [6:0]  func7;
      logic [31:0] imm;
   } fields_t;

   // True when v[31:msb] is a pure sign extension of v[msb].
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
      logic [31:0] ext;
      ext = 32'($signed(v) >>> msb);
      return (ext == '0) || (ext == '1);
   endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-in / word-out stream bundle of the instruction encoder.
interface inst_encoder_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        in_op;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [2:0]        in_func3;
   logic [6:0]        in_func7;
   logic [31:0]       in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_inst;
   logic [ADDR_W-1:0] out_addr;
   logic              out_err;

   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_func3, in_func7, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_addr, out_err
   );

   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_func3, in_func7, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_addr, out_err
   );
endinterface

// File: rtl/inst_encoder_imm_pack.sv
// Combinational RV32I word packer with immediate range check; zero latency, no handshake.
module imm_pack
   import rv32_pkg::*;
(
   input  logic [6:0]  op,
   input  logic [2:0]  func3,
   input  logic [6:0]  func7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] inst,
   output logic        err
);

   always_comb begin
      inst = NOP_INST;
      err  = 1'b0;
      case (op)
         OP_LUI, OP_AUIPC: begin
            inst = {imm[31:12], rd, op};
            err  = |imm[11:0];
         end
         OP_JAL: begin
            inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            err  = imm[0] | !fits_signed(imm, 20);
         end
         OP_JALR, OP_LOAD: begin
            inst = {imm[11:0], rs1, func3, rd, op};
            err  = !fits_signed(imm, 11);
         end
         OP_BRANCH: begin
            inst = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], op};
            err  = imm[0] | !fits_signed(imm, 12);
         end
         OP_STORE: begin
            inst = {imm[11:5], rs2, rs1, func3, imm[4:0], op};
            err  = !fits_signed(imm, 11);
         end
         OP_IMM: begin
            // Shift amounts are unsigned and live where imm[4:0] would be.
            if (func3 == F3_SLL || func3 == F3_SRX) begin
               inst = {func7, imm[4:0], rs1, func3, rd, op};
               err  = |imm[31:5];
            end else begin
               inst = {imm[11:0], rs1, func3, rd, op};
               err  = !fits_signed(imm, 11);
            end
         end
         OP_OP: begin
            inst = {func7, rs2, rs1, func3, rd, op};
         end
         default: begin
            inst = NOP_INST;
            err  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder with address and error counters; latency 2 cycles.
// Valid/ready on both sides: S1 holds while S2 is stalled, in_ready drops only when both are full.
module inst_encoder
   import rv32_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   inst_encoder_if.slave bus,
   output logic [7:0]    err_cnt
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   fields_t           s1_q, s1_d;
   logic              s1_valid_q, s1_valid_d;
   logic              s2_valid_q, s2_valid_d;
   logic [31:0]       s2_inst_q, s2_inst_d;
   logic              s2_err_q, s2_err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic [31:0]       pack_inst;
   logic              pack_err;
   logic              s1_adv;
   logic              accept;
   logic              xfer;

   imm_pack u_pack (
      .op    (s1_q.op),
      .func3 (s1_q.func3),
      .func7 (s1_q.func7),
      .rd    (s1_q.rd),
      .rs1   (s1_q.rs1),
      .rs2   (s1_q.rs2),
      .imm   (s1_q.imm),
      .inst  (pack_inst),
      .err   (pack_err)
   );

   assign s1_adv       = !s2_valid_q || bus.out_ready;
   assign bus.in_ready = !rst && !flush && (!s1_valid_q || s1_adv);
   assign accept       = bus.in_valid && bus.in_ready;
   assign xfer         = s2_valid_q && bus.out_ready;

   always_comb begin
      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      s2_inst_d  = s2_inst_q;
      s2_err_d   = s2_err_q;
      addr_d     = addr_q;
      err_cnt_d  = err_cnt_q;

      if (accept) begin
         s1_d.op    = bus.in_op;
         s1_d.rd    = bus.in_rd;
         s1_d.rs1   = bus.in_rs1;
         s1_d.rs2   = bus.in_rs2;
         s1_d.func3 = bus.in_func3;
         s1_d.func7 = bus.in_func7;
         s1_d.imm   = bus.in_imm;
         s1_valid_d = 1'b1;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      // The last word stays on out_inst after it drains; only out_valid drops.
      if (s1_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_inst_d = pack_inst;
            s2_err_d  = pack_err;
         end
      end

      if (xfer) begin
         addr_d = addr_q + 1'b1;
         if (s2_err_q && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end

      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
         s2_inst_d  = '0;
         s2_err_d   = 1'b0;
         addr_d     = BASE;
         err_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q       <= '0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_inst_q  <= '0;
         s2_err_q   <= 1'b0;
         addr_q     <= BASE;
         err_cnt_q  <= '0;
      end else begin
         s1_q       <= s1_d;
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s2_inst_q  <= s2_inst_d;
         s2_err_q   <= s2_err_d;
         addr_q     <= addr_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.out_valid = s2_valid_q;
   assign bus.out_inst  = s2_inst_q;
   assign bus.out_err   = s2_err_q;
   assign bus.out_addr  = addr_q;
   assign err_cnt       = err_cnt_q;

endmodule
